pc_fetch: RTL

Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the memory's byte address. It captures the combinationally returned 32-bit big-endian instruction word into an IF/ID output register, which it hands to decode over a valid/ready handshake. It supports start/stop control, branch/jump redirect with flush, stall on downstream back-pressure, and address wrap-around at the end of the memory.

---
 rtl/pc_fetch_pkg.sv | 23 ++
 rtl/pc_fetch_if.sv | 23 ++
 rtl/pc_fetch_pc_reg.sv | 51 +++++
 rtl/pc_fetch.sv | 92 +++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its decode neighbour.
// Holds data widths, the fetch FSM state type and opcode field positions.
package pc_fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // All-zero word decodes as a no-op; it is also what the IF/ID register resets to.
    localparam logic [INST_W-1:0] NOP_INST   = '0;
    localparam int unsigned       OPCODE_MSB = 31;
    localparam int unsigned       OPCODE_LSB = 26;
    localparam logic [5:0]        OPC_RTYPE  = 6'h00;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Memory address/data pair plus the IF/ID valid/ready handshake toward decode.
// The fetch stage is the master; memory and decode together form the slave side.
interface pc_fetch_if;

    logic [pc_fetch_pkg::ADDR_W-1:0] pc;
    logic [pc_fetch_pkg::INST_W-1:0] inst;
    logic                            out_valid;
    logic                            out_ready;
    logic [pc_fetch_pkg::INST_W-1:0] out_inst;
    logic [pc_fetch_pkg::ADDR_W-1:0] out_pc;
    logic [pc_fetch_pkg::ADDR_W-1:0] out_pc4;

    modport master (
        output pc, out_valid, out_inst, out_pc, out_pc4,
        input  inst, out_ready
    );

    modport slave (
        input  pc, out_valid, out_inst, out_pc, out_pc4,
        output inst, out_ready
    );

endinterface

// File: rtl/pc_fetch_pc_reg.sv
// Program counter with +4 increment wrapped to the memory size, and redirect
// alignment with a sticky flag for targets that were not word aligned.
module pc_reg
    import pc_fetch_pkg::*;
#(
    parameter int unsigned       MEM_BYTES = 512,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic              misalign_o
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_BYTES - 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              misalign_q, misalign_d;

    assign next_pc_o  = (pc_q + ADDR_W'(4)) & ADDR_MASK;
    assign pc_o       = pc_q;
    assign misalign_o = misalign_q;

    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (redirect_i) begin
            pc_d = word_align(redirect_pc_i) & ADDR_MASK;
            if (redirect_pc_i[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (load_i) begin
            pc_d = next_pc_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: start/stop FSM, IF/ID output register and accepted-instruction
// counter around the pc_reg program counter.
//
//   state | meaning
//   IDLE  | PC held, no new fetch; a pending valid output waits for decode
//   RUN   | fetch one word per cycle whenever the IF/ID register can take it
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int unsigned       MEM_BYTES = 512,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    pc_fetch_if.master        bus_if,
    output logic              misalign_o,
    output logic [31:0]       fetch_count_o
);

    state_e            state_q, state_d;
    logic              out_valid_q;
    logic [INST_W-1:0] out_inst_q;
    logic [ADDR_W-1:0] out_pc_q, out_pc4_q;
    logic [31:0]       count_q;
    logic              load, accept;
    logic [ADDR_W-1:0] pc, next_pc;

    assign accept = out_valid_q && bus_if.out_ready;
    // A redirect flushes the slot, so it also suppresses the load in that cycle.
    assign load   = (state_q == RUN) && (!out_valid_q || bus_if.out_ready) && !redirect_i;

    always_comb begin
        state_d = state_q;
        if (stop_i) begin
            state_d = IDLE;
        end else if (start_i) begin
            state_d = RUN;
        end
    end

    pc_reg #(
        .MEM_BYTES (MEM_BYTES),
        .RESET_PC  (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (load),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc),
        .next_pc_o     (next_pc),
        .misalign_o    (misalign_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_inst_q  <= NOP_INST;
            out_pc_q    <= '0;
            out_pc4_q   <= '0;
            count_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                count_q <= count_q + 32'd1;
            end
            if (redirect_i) begin
                out_valid_q <= 1'b0;
            end else if (load) begin
                out_valid_q <= 1'b1;
                out_inst_q  <= bus_if.inst;
                out_pc_q    <= pc;
                out_pc4_q   <= next_pc;
            end else if (accept) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus_if.pc        = pc;
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.out_inst  = out_inst_q;
    assign bus_if.out_pc    = out_pc_q;
    assign bus_if.out_pc4   = out_pc4_q;
    assign fetch_count_o    = count_q;

endmodule
